// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register addresses ({rd,sel}) and exception codes.
package cp0_regs_pkg;

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Address-error exceptions are the only ones that capture a faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with clock prescaler and sticky timer interrupt.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_load,
  input  logic [31:0] count_wdata,
  input  logic        compare_load,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;
  logic [31:0]   count_inc;

  // Next-state: a Count load restarts the prescaler; a Compare load clears TI last so it wins.
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    tick      = (presc_q == PRESC_LAST);
    count_inc = count_q + 32'd1;
    if (count_load) begin
      count_d = count_wdata;
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      count_d = count_inc;
      if (count_inc == compare_q) begin
        ti_d = 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (compare_load) begin
      compare_d = compare_wdata;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: Status/Cause/EPC/BadVAddr, exception/ERET commit and interrupt request.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mtc0_we,
  input  logic [7:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [7:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic                  int_req,
  output logic                  exc_flush,
  output logic [31:0]           flush_pc,
  output logic                  status_exl,
  output logic [31:0]           epc
);

  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [7:0]  im_q, im_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [5:0]  hw_pad;
  logic [7:0]  ip;
  logic        count_load, compare_load;
  logic [31:0] count, compare;
  logic        ti;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .count_load    (count_load),
    .count_wdata   (mtc0_wdata),
    .compare_load  (compare_load),
    .compare_wdata (mtc0_wdata),
    .count         (count),
    .compare       (compare),
    .ti            (ti)
  );

  // Widen the external interrupt lines to six; lines beyond HW_INT_NUM stay zero.
  always_comb begin
    hw_pad = '0;
    hw_pad[HW_INT_NUM-1:0] = hw_int;
  end

  // Commit priority: exception, then ERET, then mtc0; lower actions are dropped.
  always_comb begin
    exl_d        = exl_q;
    ie_d         = ie_q;
    im_d         = im_q;
    bd_d         = bd_q;
    exc_code_d   = exc_code_q;
    epc_d        = epc_q;
    badvaddr_d   = badvaddr_q;
    ip_sw_d      = ip_sw_q;
    ip_hw_d      = hw_pad;
    count_load   = 1'b0;
    compare_load = 1'b0;
    if (exc_valid) begin
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end
      exl_d      = 1'b1;
      exc_code_d = exc_code;
      if (is_addr_exc(exc_code)) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc0_we) begin
      // BadVAddr is read-only from software.
      case (mtc0_addr)
        CP0_STATUS: begin
          im_d  = mtc0_wdata[15:8];
          exl_d = mtc0_wdata[1];
          ie_d  = mtc0_wdata[0];
        end
        CP0_CAUSE:   ip_sw_d      = mtc0_wdata[9:8];
        CP0_EPC:     epc_d        = mtc0_wdata;
        CP0_COUNT:   count_load   = 1'b1;
        CP0_COMPARE: compare_load = 1'b1;
        default:     ;
      endcase
    end
  end

  // Architectural register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      im_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  // IP[7] merges the timer interrupt with the sixth hardware line.
  assign ip = {ti | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};

  // Register read port; returns pre-edge values for same-cycle writes.
  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_rdata = badvaddr_q;
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
      CP0_STATUS:   mfc0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      CP0_CAUSE:    mfc0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
      CP0_EPC:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign int_req    = ie_q & ~exl_q & (|(ip & im_q));
  assign exc_flush  = exc_valid | eret;
  assign flush_pc   = exc_valid ? EXC_VECTOR : epc_q;
  assign status_exl = exl_q;
  assign epc        = epc_q;

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 SHALL have parameter HW_INT_NUM, default 6, number of hardware interrupt lines (1..6) mapped to Cause.IP[2+i].
REQ-002 SHALL have parameter COUNT_DIV, default 2, clock cycles per Count increment (>=1).
REQ-003 SHALL have parameter EXC_VECTOR, default 32'hbfc00380, exception entry PC.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports mtc0_we in 1, mtc0_addr in 8 ({rd,sel}), mtc0_wdata in 32: register write from WB.
REQ-007 SHALL have ports mfc0_addr in 8, mfc0_rdata out 32: combinational register read.
REQ-008 SHALL have ports exc_valid in 1, exc_code in 5, exc_pc in 32, exc_bd in 1, exc_badvaddr in 32: exception commit from WB.
REQ-009 SHALL have port eret  in  1  ERET commit from WB.
REQ-010 SHALL have port hw_int  in  HW_INT_NUM  level-sensitive external interrupts.
REQ-011 SHALL have outputs int_req 1, exc_flush 1, flush_pc 32, status_exl 1, epc 32.

Function
REQ-012 SHALL map BadVAddr=8'h40, Count=8'h48, Compare=8'h58, Status=8'h60, Cause=8'h68, EPC=8'h70; other addresses read 0, writes ignored.
REQ-013 SHALL read Status as {9'b0, BEV=1, 6'b0, IM[7:0], 6'b0, EXL, IE}; only IM, EXL, IE writable.
REQ-014 SHALL read Cause as {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}; only IP[1:0] writable via mtc0.
REQ-015 SHALL give per-edge priority exc_valid > eret > mtc0; a lower-priority action in the same cycle is dropped entirely.
REQ-016 On exc_valid with EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc, BD <= exc_bd; with EXL=1 EPC and BD hold.
REQ-017 On any exc_valid: EXL <= 1, ExcCode <= exc_code; BadVAddr <= exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
REQ-018 On eret (no exc_valid): EXL <= 0.
REQ-019 SHALL drive exc_flush = exc_valid | eret and flush_pc = exc_valid ? EXC_VECTOR : EPC, combinationally, same cycle.
REQ-020 SHALL keep a prescaler 0..COUNT_DIV-1; Count increments (mod 2^32) on the cycle the prescaler wraps.
REQ-021 mtc0 to Count SHALL load Count and clear the prescaler, overriding any same-cycle increment.
REQ-022 SHALL set TI on the edge where the incremented Count value equals Compare; TI stays set until cleared.
REQ-023 mtc0 to Compare SHALL load Compare and clear TI; clear wins over a same-cycle set.
REQ-024 SHALL register hw_int each cycle: IP[2+i] <= hw_int[i]; IP[7] <= TI | (HW_INT_NUM==6 ? hw_int[5] : 0); unused IP bits read 0.
REQ-025 SHALL drive int_req = IE & ~EXL & |(IP & IM) combinationally from registered state.
REQ-026 SHALL drive status_exl = EXL and epc = EPC continuously.
REQ-027 mfc0 reading a register written the same cycle SHALL return the old value.

Reset
REQ-028 On reset: EXL=0, IE=0, IM=0, BD=0, TI=0, IP=0, ExcCode=0, Count=0, prescaler=0, Compare=0, BadVAddr=0, EPC=0.
REQ-029 Outputs during reset SHALL be int_req=0, status_exl=0, epc=0; exc_flush/flush_pc follow inputs.
REQ-030 Reset asserted mid-operation SHALL discard pending TI and sampled interrupts within the same cycle.

Structure
REQ-031 CP0 register addresses, ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12) SHALL live in the shared CP0 package/header.
REQ-032 Count, Compare, prescaler and TI SHALL be a sub-module cp0_timer with load/clear inputs and count/ti outputs.

Verification
REQ-033 Exception: exc_valid, code=4, pc=32'hbfc00100, bd=1, badvaddr=32'h3 -> EPC=32'hbfc000fc, BD=1, EXL=1, BadVAddr=3, flush_pc=32'hbfc00380 same cycle.
REQ-034 Nested: second exc_valid with EXL=1, pc=32'h80000000 -> EPC unchanged, ExcCode updated; then eret -> flush_pc=old EPC, EXL=0 next cycle.
REQ-035 Timer: COUNT_DIV=2, write Count=0, Compare=5 -> TI set after 10 cycles; with IM[7]=1, IE=1 int_req=1; write Compare -> TI=0, int_req=0.
REQ-036 Priority: exc_valid+eret+mtc0 Status=0 same cycle -> only exception effects; Status.IE unchanged.
REQ-037 Interrupts: HW_INT_NUM=2, hw_int=2'b10, IM=8'h08, IE=1 -> IP=8'h08 next cycle, int_req=1; software IP[0] write with IM[0]=1 -> int_req=1.
REQ-038 Async reset asserted between clock edges -> all registers zero immediately, int_req=0 before next edge.
